imem_arbiter: RTL

- Sequences and shares the single-port instruction memory between the fetch stage (reads) and a host program loader (writes).
- Owns the core run/halt state: holds the core in LOAD until a program is written, runs it, and halts on ECALL.
- Drives the PC enable for the fetch/BTB logic.
- Sits between fetch, the instruction memory macro and the host/testbench loader port.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_starve_ctr.sv | 48 ++++
 rtl/imem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory arbiter and fetch.
//   imem_state_e : core run state (LOAD / RUN / HALT)
//   IMEM_ADDR_W  : default word-address width of the instruction memory
//   ECALL_INSN   : ECALL encoding, shared with the fetch decoder
// ----------------------------------------------------------------------------
package imem_pkg;

    localparam int          IMEM_ADDR_W = 16;
    localparam logic [31:0] ECALL_INSN  = 32'h0000_0073;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_starve_ctr.sv
// ----------------------------------------------------------------------------
// imem_starve_ctr
// Counts consecutive cycles a pending loader write is blocked by fetch while
// the core runs, and raises o_force_load once MAX_WAIT blocked cycles have
// elapsed so the next cycle goes to the loader.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_run          : arbiter is in RUN
//   i_load_valid   : loader write pending
//   i_load_gnt     : loader granted this cycle
//   o_force_load   : grant the loader unconditionally this cycle
// ----------------------------------------------------------------------------
module imem_starve_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_load_valid,
    input  logic i_load_gnt,
    output logic o_force_load
);

    localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_d;

    always_comb begin
        w_wait_cnt_d = r_wait_cnt;
        if (!i_run || !i_load_valid || i_load_gnt) begin
            w_wait_cnt_d = 4'd0;
        end else if (r_wait_cnt != LP_MAX) begin
            w_wait_cnt_d = r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= 4'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    assign o_force_load = i_run && i_load_valid && (r_wait_cnt == LP_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
// Shares the single-port instruction memory between fetch (reads) and the
// host program loader (writes), and owns the core LOAD/RUN/HALT state.
// Optional feature macro: IMEM_STALL_CNT_EN adds o_stall_cnt, a saturating
// count of RUN cycles where fetch requested but was not granted.
// Ports:
//   i_clk, i_rst_n                  : clock, async active-low reset
//   i_fetch_req/addr, o_fetch_gnt   : fetch request / grant
//   o_fetch_rvalid/rdata            : read return, one cycle after grant
//   i_ecall                         : ECALL decoded, halts the core
//   i_load_valid/addr/data          : loader write request
//   o_load_ready                    : loader write accepted
//   i_load_done                     : pulse, start (or restart) the core
//   o_mem_en/we/addr/wdata, i_mem_rdata : memory macro interface
//   o_pc_enable                     : PC advance enable
//   o_halted                        : core stopped by ECALL
//   o_stall_cnt (IMEM_STALL_CNT_EN) : blocked-fetch cycle counter
// ----------------------------------------------------------------------------
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W   = IMEM_ADDR_W,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_gnt,
    output logic              o_fetch_rvalid,
    output logic [DATA_W-1:0] o_fetch_rdata,
    input  logic              i_ecall,
    input  logic              i_load_valid,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_ready,
    input  logic              i_load_done,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_pc_enable,
    output logic              o_halted
`ifdef IMEM_STALL_CNT_EN
    ,
    output logic [31:0]       o_stall_cnt
`endif
);

    imem_state_e r_state;
    imem_state_e w_state_d;
    logic        r_fetch_rvalid;
    logic        w_run;
    logic        w_force_load;

    assign w_run = (r_state == RUN);

    imem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_run        (w_run),
        .i_load_valid (i_load_valid),
        .i_load_gnt   (o_load_ready),
        .o_force_load (w_force_load)
    );

    // Grants: fetch wins in RUN unless the loader has starved for MAX_WAIT
    // cycles, in which case the PC holds for the cycle the write goes through.
    always_comb begin
        o_fetch_gnt  = 1'b0;
        o_load_ready = 1'b0;
        o_pc_enable  = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_force_load) begin
                    o_load_ready = 1'b1;
                end else if (i_fetch_req) begin
                    o_fetch_gnt = 1'b1;
                    o_pc_enable = 1'b1;
                end else begin
                    o_load_ready = i_load_valid;
                    o_pc_enable  = 1'b1;
                end
            end
            default: begin
                o_load_ready = i_load_valid;
            end
        endcase
    end

    // ecall is checked first so it wins over a simultaneous load_done.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            LOAD:    if (i_load_done) w_state_d = RUN;
            RUN:     if (i_ecall) w_state_d = HALT;
            HALT:    if (i_load_done) w_state_d = RUN;
            default: w_state_d = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= LOAD;
            r_fetch_rvalid <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_fetch_rvalid <= o_fetch_gnt;
        end
    end

    assign o_halted       = (r_state == HALT);
    assign o_fetch_rvalid = r_fetch_rvalid;
    assign o_fetch_rdata  = i_mem_rdata;

    assign o_mem_en    = o_fetch_gnt | o_load_ready;
    assign o_mem_we    = o_load_ready;
    assign o_mem_addr  = o_load_ready ? i_load_addr : i_fetch_addr;
    assign o_mem_wdata = i_load_data;

`ifdef IMEM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == LOAD) && (w_state_d == RUN)) begin
            r_stall_cnt <= 32'd0;
        end else if (w_run && i_fetch_req && !o_fetch_gnt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
